pipeline_wb_arbiter: RTL

//  Shares the single register-file write port between the in-order W stage and one

---
 rtl/pipeline_wb_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipeline_wb_arbiter.sv
// rtl/pipeline_wb_arbiter.sv - regfile write-port arbiter between W stage and long-latency unit
// Optional pending-register scoreboard enabled by defining WB_ARB_SCOREBOARD_EN.
module pipeline_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_pipe_wr_en,
  input  logic [4:0]      i_pipe_rd_addr,
  input  logic [XLEN-1:0] i_pipe_wr_data,
  input  logic            i_lu_valid,
  input  logic [4:0]      i_lu_rd_addr,
  input  logic [XLEN-1:0] i_lu_wr_data,
  output logic            o_lu_ready,
  output logic            o_stall_pipe,
  output logic            o_rf_wr_en,
  output logic [4:0]      o_rf_rd_addr,
  output logic [XLEN-1:0] o_rf_wr_data,
  input  logic            i_lu_issue,
  input  logic [4:0]      i_lu_issue_rd,
  input  logic [4:0]      i_dec_rs1,
  input  logic [4:0]      i_dec_rs2,
  output logic            o_sb_hazard
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ARB, FORCE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rf_wr_en_q, rf_wr_en_d;
  logic [4:0]        rf_rd_addr_q, rf_rd_addr_d;
  logic [XLEN-1:0]   rf_wr_data_q, rf_wr_data_d;

  logic pipe_eff;
  logic lu_hs;

  // A W-stage write to x0 is a no-op and must not block the LU.
  assign pipe_eff     = i_pipe_wr_en && (i_pipe_rd_addr != 5'd0);
  assign o_stall_pipe = (state_q == FORCE);
  assign o_lu_ready   = (state_q == FORCE) ? 1'b1 : !pipe_eff;
  assign lu_hs        = i_lu_valid && o_lu_ready;

  assign o_rf_wr_en   = rf_wr_en_q;
  assign o_rf_rd_addr = rf_rd_addr_q;
  assign o_rf_wr_data = rf_wr_data_q;

  // Next-state: pick the granted writer, track LU starvation, decide on a forced grant.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_addr_d = rf_rd_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    case (state_q)
      ARB: begin
        if (pipe_eff) begin
          rf_wr_en_d   = 1'b1;
          rf_rd_addr_d = i_pipe_rd_addr;
          rf_wr_data_d = i_pipe_wr_data;
        end else if (lu_hs && (i_lu_rd_addr != 5'd0)) begin
          rf_wr_en_d   = 1'b1;
          rf_rd_addr_d = i_lu_rd_addr;
          rf_wr_data_d = i_lu_wr_data;
        end
        // This denial is the one that reaches the limit: steal the next cycle.
        if (i_lu_valid && !o_lu_ready && (cnt_q == CNT_W'(STARVE_LIMIT - 1)))
          state_d = FORCE;
      end
      FORCE: begin
        // Pipe input is ignored here; the frozen W register re-presents it next cycle.
        if (lu_hs && (i_lu_rd_addr != 5'd0)) begin
          rf_wr_en_d   = 1'b1;
          rf_rd_addr_d = i_lu_rd_addr;
          rf_wr_data_d = i_lu_wr_data;
        end
        state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    if (!i_lu_valid || lu_hs)
      cnt_d = '0;
    else if (cnt_q != CNT_W'(STARVE_LIMIT))
      cnt_d = cnt_q + 1'b1;
  end

  // Arbiter state and registered write-port outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q      <= ARB;
      cnt_q        <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_addr_q <= 5'd0;
      rf_wr_data_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

`ifdef WB_ARB_SCOREBOARD_EN
  logic [31:0] pend_q, pend_d;

  // Pending-rd mask: clear on LU completion first so a same-cycle issue of that rd wins.
  always_comb begin
    pend_d = pend_q;
    if (lu_hs)
      pend_d[i_lu_rd_addr] = 1'b0;
    if (i_lu_issue && (i_lu_issue_rd != 5'd0))
      pend_d[i_lu_issue_rd] = 1'b1;
  end

  // Pending mask register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn)
      pend_q <= '0;
    else
      pend_q <= pend_d;
  end

  assign o_sb_hazard = ((i_dec_rs1 != 5'd0) && pend_q[i_dec_rs1]) ||
                       ((i_dec_rs2 != 5'd0) && pend_q[i_dec_rs2]);
`else
  // Scoreboard inputs are accepted but have no effect in this build.
  assign o_sb_hazard = 1'b0 & (^{i_lu_issue, i_lu_issue_rd, i_dec_rs1, i_dec_rs2});
`endif

endmodule
